// File: rtl/clock_pkg.sv
// Shared constants for the clock display: source indices, arbiter FSM states, blank code.
package clock_pkg;

  localparam int NUM_SRC = 3;

  localparam logic [1:0] SRC_SW   = 2'd0;
  localparam logic [1:0] SRC_TMR  = 2'd1;
  localparam logic [1:0] SRC_ALM  = 2'd2;
  localparam logic [1:0] SRC_NONE = 2'd3;

  localparam logic [3:0] BLANK = 4'hF;

  typedef enum logic {
    NORMAL = 1'b0,
    URGENT = 1'b1
  } state_t;

  // Highest-index set bit wins: alarm over timer over stopwatch.
  function automatic logic [1:0] top_pending(input logic [NUM_SRC-1:0] p);
    if (p[2])      return SRC_ALM;
    else if (p[1]) return SRC_TMR;
    else           return SRC_SW;
  endfunction

endpackage

// File: rtl/display_scan.sv
// Four-digit multiplex scan: slot index advances on each 1 ms tick, wraps 3 -> 0.
// slot_an is the combinational active-low anode for the current slot.
module display_scan (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  output logic [1:0] scan,
  output logic [3:0] slot_an
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     scan <= 2'd0;
    else if (tick) scan <= scan + 2'd1;
  end

  assign slot_an = ~(4'b0001 << scan);

endmodule

// File: rtl/display_arbiter.sv
// Chooses which source drives the 4-digit display, latching urgent events and serving them
// highest-first with whole-display blink; all outputs registered one cycle after state/scan.
module display_arbiter
  import clock_pkg::*;
#(
  parameter int URGENT_TIMEOUT_S = 30,
  parameter int BLINK_HALF_MS    = 500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_1ms,
  input  logic        tick_1hz,
  input  logic [1:0]  mode_sel,
  input  logic [15:0] src0_digits,
  input  logic [15:0] src1_digits,
  input  logic [15:0] src2_digits,
  input  logic [3:0]  src0_blink,
  input  logic [3:0]  src1_blink,
  input  logic [3:0]  src2_blink,
  input  logic [2:0]  urgent_req,
  input  logic        urgent_ack,
  output logic [3:0]  an,
  output logic [3:0]  digit_out,
  output logic [2:0]  grant,
  output logic        urgent_active,
  output logic [2:0]  pending
);

  localparam int SEC_W = $clog2(URGENT_TIMEOUT_S + 1);
  localparam int MS_W  = $clog2(BLINK_HALF_MS + 1);
  localparam logic [SEC_W-1:0] SEC_LAST  = SEC_W'(URGENT_TIMEOUT_S - 1);
  localparam logic [SEC_W-1:0] SEC_MAX   = SEC_W'(URGENT_TIMEOUT_S);
  localparam logic [MS_W-1:0]  MS_RELOAD = MS_W'(BLINK_HALF_MS);

  state_t               state, state_n;
  logic [1:0]           served, served_n;
  logic [NUM_SRC-1:0]   req_q, rise, pending_n, served_mask;
  logic [SEC_W-1:0]     sec_cnt, sec_cnt_n;
  logic [MS_W-1:0]      ms_cnt, ms_cnt_n, ms_inc;
  logic                 phase_on, phase_on_n;
  logic                 enter, leave, timeout;
  logic [1:0]           scan;
  logic [3:0]           slot_an;
  logic [1:0]           disp_src;
  logic [15:0]          disp_digits;
  logic [3:0]           disp_blink;
  logic                 blank;

  display_scan u_scan (
    .clk     (clk),
    .reset   (reset),
    .tick    (tick_1ms),
    .scan    (scan),
    .slot_an (slot_an)
  );

  assign rise        = urgent_req & ~req_q;
  assign served_mask = NUM_SRC'(1) << served;
  assign timeout     = tick_1hz && (sec_cnt == SEC_LAST);
  assign leave       = (state == URGENT) && (urgent_ack || timeout);

  // Exit and re-entry share one edge so a queued event is served without a NORMAL gap.
  always_comb begin
    state_n   = state;
    served_n  = served;
    pending_n = pending | rise;
    enter     = 1'b0;
    case (state)
      NORMAL: begin
        if (pending != '0) begin
          state_n  = URGENT;
          served_n = top_pending(pending);
          enter    = 1'b1;
        end
      end
      URGENT: begin
        if (leave) begin
          pending_n = (pending & ~served_mask) | rise;
          if (pending_n != '0) begin
            served_n = top_pending(pending_n);
            enter    = 1'b1;
          end else begin
            state_n = NORMAL;
          end
        end
      end
      default: state_n = NORMAL;
    endcase
  end

  // Blink phase free-runs in NORMAL and restarts in the on phase at every urgent entry.
  always_comb begin
    sec_cnt_n  = sec_cnt;
    ms_cnt_n   = ms_cnt;
    phase_on_n = phase_on;
    ms_inc     = ms_cnt + MS_W'(1);
    if (enter) begin
      sec_cnt_n  = '0;
      ms_cnt_n   = '0;
      phase_on_n = 1'b1;
    end else begin
      if ((state == URGENT) && tick_1hz && (sec_cnt != SEC_MAX))
        sec_cnt_n = sec_cnt + SEC_W'(1);
      if (tick_1ms) begin
        if (ms_inc == MS_RELOAD) begin
          ms_cnt_n   = '0;
          phase_on_n = ~phase_on;
        end else begin
          ms_cnt_n = ms_inc;
        end
      end
    end
  end

  always_comb begin
    disp_src = (state_n == URGENT) ? served_n : mode_sel;
    case (disp_src)
      SRC_SW:  begin disp_digits = src0_digits; disp_blink = src0_blink; end
      SRC_TMR: begin disp_digits = src1_digits; disp_blink = src1_blink; end
      SRC_ALM: begin disp_digits = src2_digits; disp_blink = src2_blink; end
      default: begin disp_digits = {4{BLANK}};  disp_blink = 4'b0000;    end
    endcase
    if (state_n == URGENT)
      blank = ~phase_on_n;
    else
      blank = (disp_src == SRC_NONE) || (~phase_on_n && disp_blink[scan]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= NORMAL;
      served        <= SRC_SW;
      req_q         <= '0;
      pending       <= '0;
      sec_cnt       <= '0;
      ms_cnt        <= '0;
      phase_on      <= 1'b1;
      an            <= 4'b1111;
      digit_out     <= BLANK;
      grant         <= 3'b000;
      urgent_active <= 1'b0;
    end else begin
      state         <= state_n;
      served        <= served_n;
      req_q         <= urgent_req;
      pending       <= pending_n;
      sec_cnt       <= sec_cnt_n;
      ms_cnt        <= ms_cnt_n;
      phase_on      <= phase_on_n;
      an            <= blank ? 4'b1111 : slot_an;
      digit_out     <= blank ? BLANK : disp_digits[{scan, 2'b00} +: 4];
      grant         <= (disp_src == SRC_NONE) ? 3'b000 : (3'b001 << disp_src);
      urgent_active <= (state_n == URGENT);
    end
  end

endmodule

// File: tb/tb_display_arbiter.sv
// Directed scenarios then random traffic, every cycle compared against an event-level model.
module tb_display_arbiter;
  import clock_pkg::*;

  localparam int TMO  = 30;
  localparam int HALF = 500;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick_1ms, tick_1hz, urgent_ack;
  logic [1:0]  mode_sel;
  logic [15:0] src0_digits, src1_digits, src2_digits;
  logic [3:0]  src0_blink, src1_blink, src2_blink;
  logic [2:0]  urgent_req;
  logic [3:0]  an, digit_out;
  logic [2:0]  grant, pending;
  logic        urgent_active;

  int checks = 0;
  int errors = 0;

  // Model: events, ticks since the last anchor (reset or urgent entry), seconds while urgent.
  bit         m_urg;
  int         m_served, m_k, m_secs, m_scan;
  bit [2:0]   m_pend, m_prev;
  logic [3:0] e_an, e_dig;
  logic [2:0] e_grant;

  logic [3:0] an_seq  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [3:0] dig_seq [4] = '{4'h0, 4'h3, 4'h1, 4'h0};
  int blanks;

  display_arbiter #(.URGENT_TIMEOUT_S(TMO), .BLINK_HALF_MS(HALF)) dut (
    .clk(clk), .reset(reset), .tick_1ms(tick_1ms), .tick_1hz(tick_1hz),
    .mode_sel(mode_sel),
    .src0_digits(src0_digits), .src1_digits(src1_digits), .src2_digits(src2_digits),
    .src0_blink(src0_blink), .src1_blink(src1_blink), .src2_blink(src2_blink),
    .urgent_req(urgent_req), .urgent_ack(urgent_ack),
    .an(an), .digit_out(digit_out), .grant(grant),
    .urgent_active(urgent_active), .pending(pending)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int highest(input bit [2:0] p);
    for (int i = 2; i >= 0; i--) if (p[i]) return i;
    return -1;
  endfunction

  function automatic logic [15:0] digits_of(input int s);
    if (s == 0) return src0_digits;
    if (s == 1) return src1_digits;
    if (s == 2) return src2_digits;
    return 16'hFFFF;
  endfunction

  function automatic logic [3:0] blink_of(input int s);
    if (s == 0) return src0_blink;
    if (s == 1) return src1_blink;
    if (s == 2) return src2_blink;
    return 4'b0000;
  endfunction

  task automatic model_reset();
    m_urg = 0; m_served = 0; m_pend = '0; m_prev = '0;
    m_k = 0; m_secs = 0; m_scan = 0;
  endtask

  task automatic model_edge();
    bit [2:0]    rise;
    bit          entering, phase_on, blank;
    int          src;
    logic [15:0] d;
    logic [3:0]  bl;
    rise = urgent_req & ~m_prev;
    m_prev = urgent_req;
    entering = 0;
    if (m_urg) begin
      if (tick_1hz) m_secs++;
      if (urgent_ack || m_secs == TMO) begin
        m_pend[m_served] = 1'b0;
        m_pend |= rise;
        if (m_pend != 0) begin m_served = highest(m_pend); entering = 1; end
        else m_urg = 0;
      end else begin
        m_pend |= rise;
      end
    end else begin
      if (m_pend != 0) begin m_urg = 1; m_served = highest(m_pend); entering = 1; end
      m_pend |= rise;
    end
    if (entering) begin m_secs = 0; m_k = 0; end
    else if (tick_1ms) m_k++;

    phase_on = ((m_k / HALF) % 2) == 0;
    src = m_urg ? m_served : int'(mode_sel);
    d = digits_of(src);
    bl = blink_of(src);
    if (m_urg) blank = !phase_on;
    else       blank = (src == 3) || (!phase_on && bl[m_scan]);
    e_grant = (src == 3) ? 3'b000 : 3'(1 << src);
    e_an    = blank ? 4'b1111 : ~(4'(1 << m_scan));
    e_dig   = blank ? 4'hF : d[m_scan*4 +: 4];
    if (tick_1ms) m_scan = (m_scan + 1) % 4;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    chk("an",            32'(an),            32'(e_an));
    chk("digit_out",     32'(digit_out),     32'(e_dig));
    chk("grant",         32'(grant),         32'(e_grant));
    chk("urgent_active", 32'(urgent_active), 32'(m_urg));
    chk("pending",       32'(pending),       32'(m_pend));
    urgent_ack = 1'b0;
    tick_1hz   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    chk("rst_an",      32'(an),            32'(4'b1111));
    chk("rst_digit",   32'(digit_out),     32'(4'hF));
    chk("rst_grant",   32'(grant),         32'(3'b000));
    chk("rst_urgent",  32'(urgent_active), 32'(1'b0));
    chk("rst_pending", 32'(pending),       32'(3'b000));
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0; tick_1ms = 0; tick_1hz = 0; urgent_ack = 0; urgent_req = '0;
    mode_sel = 2'd3;
    src0_digits = 16'h0000; src1_digits = 16'h0000; src2_digits = 16'h0000;
    src0_blink = '0; src1_blink = '0; src2_blink = '0;
    #2;
    do_reset();

    // Timer source scanned digit by digit.
    mode_sel = 2'd1; src1_digits = 16'h0130;
    cycle();
    chk("mode1_grant", 32'(grant), 32'(3'b010));
    tick_1ms = 1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("scan_an",    32'(an),        32'(an_seq[i]));
      chk("scan_digit", 32'(digit_out), 32'(dig_seq[i]));
    end
    tick_1ms = 0;

    // Urgent request from the timer: latch, enter, blink half of each period.
    urgent_req = 3'b010;
    cycle();
    chk("req_pending", 32'(pending), 32'(3'b010));
    chk("req_not_yet", 32'(urgent_active), 32'(1'b0));
    cycle();
    chk("urgent_entry", 32'(urgent_active), 32'(1'b1));
    chk("urgent_grant", 32'(grant), 32'(3'b010));
    tick_1ms = 1; blanks = 0;
    repeat (1000) begin
      cycle();
      if (an == 4'b1111) blanks++;
    end
    chk("urgent_blank_count", 32'(blanks), 32'd500);
    tick_1ms = 0;

    // Two pending events acknowledged in turn.
    urgent_req = 3'b011;
    cycle();
    chk("two_pending", 32'(pending), 32'(3'b011));
    chk("no_preempt",  32'(grant),   32'(3'b010));
    urgent_ack = 1;
    cycle();
    chk("ack1_pending", 32'(pending), 32'(3'b001));
    chk("ack1_grant",   32'(grant),   32'(3'b001));
    chk("ack1_urgent",  32'(urgent_active), 32'(1'b1));
    mode_sel = 2'd2; urgent_ack = 1;
    cycle();
    chk("ack2_urgent", 32'(urgent_active), 32'(1'b0));
    chk("ack2_grant",  32'(grant), 32'(3'b100));

    // Unacknowledged event times out on the 30th second.
    urgent_req = 3'b000; cycle();
    urgent_req = 3'b001; cycle(); cycle();
    for (int i = 1; i <= TMO; i++) begin
      tick_1hz = 1;
      cycle();
      chk("timeout_active", 32'(urgent_active), 32'(i < TMO));
      cycle();
    end
    chk("timeout_pending", 32'(pending), 32'(3'b000));

    // Ack coinciding with a new alarm edge, later a re-raise of the served source.
    urgent_req = 3'b000; cycle();
    urgent_req = 3'b001; cycle(); cycle();
    chk("serve0_grant", 32'(grant), 32'(3'b001));
    urgent_ack = 1; urgent_req = 3'b101;
    cycle();
    chk("ack_edge_pending", 32'(pending), 32'(3'b100));
    chk("ack_edge_grant",   32'(grant),   32'(3'b100));
    chk("ack_edge_urgent",  32'(urgent_active), 32'(1'b1));
    urgent_req = 3'b111; cycle();
    chk("late_no_preempt", 32'(grant), 32'(3'b100));
    urgent_ack = 1; cycle();
    urgent_req = 3'b101; cycle();
    urgent_ack = 1; urgent_req = 3'b111;
    cycle();
    chk("reraise_pending", 32'(pending), 32'(3'b010));
    chk("reraise_grant",   32'(grant),   32'(3'b010));
    urgent_ack = 1; cycle();
    urgent_req = 3'b000; cycle();

    // Reset while urgent discards everything.
    urgent_req = 3'b011; cycle(); cycle();
    urgent_req = 3'b000;
    do_reset();
    repeat (3) cycle();
    chk("post_reset_pending", 32'(pending), 32'(3'b000));

    // Alarm field edit blink, then reset during the off phase.
    mode_sel = 2'd2; src2_digits = 16'h1234; src2_blink = 4'b1100;
    do_reset();
    cycle();
    tick_1ms = 1; blanks = 0;
    repeat (1000) begin
      cycle();
      if (an == 4'b1111) blanks++;
    end
    chk("field_blank_count", 32'(blanks), 32'd250);
    repeat (597) cycle();
    chk("field_steady_an",    32'(an),        32'(4'b1110));
    chk("field_steady_digit", 32'(digit_out), 32'(4'h4));
    tick_1ms = 0;
    do_reset();

    // Random traffic.
    for (int n = 0; n < 5000; n++) begin
      for (int b = 0; b < 3; b++)
        if ($urandom_range(0, 19) == 0) urgent_req[b] = ~urgent_req[b];
      urgent_ack = ($urandom_range(0, 15) == 0);
      tick_1ms   = 1'($urandom_range(0, 1));
      tick_1hz   = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 99) == 0) mode_sel = 2'($urandom_range(0, 3));
      if (n % 200 == 0) begin
        src0_digits = 16'($urandom); src1_digits = 16'($urandom); src2_digits = 16'($urandom);
        src0_blink = 4'($urandom); src1_blink = 4'($urandom); src2_blink = 4'($urandom);
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
